decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter BUS_DATA_WIDTH, default 64, width of fetch response data and PC.
REQ-002 Parameter BUS_TAG_WIDTH, default 13, carried for bus compatibility; unused internally.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  begin sequencing at entry; honoured in IDLE and HALT only.
REQ-006 entry  input  64  starting PC; bits [1:0] ignored.
REQ-007 fetch_req  output  1  fetch request to bus.
REQ-008 fetch_addr  output  64  8-byte-aligned fetch address.
REQ-009 fetch_ack  input  1  bus accepted request.
REQ-010 resp_valid  input  1  fetch data present.
REQ-011 resp_data  input  64  fetched word, little-endian, low half = lower address.
REQ-012 resp_ack  output  1  one-cycle pulse consuming resp_data.
REQ-013 instr_valid  output  1  instruction offered to decoders.
REQ-014 instr  output  32  instruction bits.
REQ-015 instr_fmt  output  3  format: R=0, I=1, S=2, SB=3, U=4, UJ=5, ILL=7.
REQ-016 instr_pc  output  64  address of instr.
REQ-017 instr_ready  input  1  decoder accepts instr.
REQ-018 halt  output  1  all-zero instruction reached.

Function
REQ-019 FSM states IDLE, REQ, WAIT, ISSUE, HALT SHALL exist.
REQ-020 IDLE: start -> latch pc=entry with bits [1:0] cleared, go to REQ next cycle.
REQ-021 REQ: fetch_req=1, fetch_addr={pc[63:3],3'b000}; fetch_ack -> WAIT; held until ack.
REQ-022 WAIT: resp_valid -> capture resp_data, resp_ack=1 same cycle, slot=pc[2], go ISSUE; resp_valid outside WAIT ignored, resp_ack=0.
REQ-023 ISSUE: instr_valid=1, instr=slot ? buf[63:32] : buf[31:0], instr_pc=pc, instr_fmt from opcode instr[6:0].
REQ-024 Opcode map: 0110011,0111011->R; 0000011,0010011,0011011,1100111->I; 0100011->S; 1100011->SB; 0110111,0010111->U; 1101111->UJ; others->ILL; ILL SHALL still be issued.
REQ-025 Handshake: transfer when instr_valid&&instr_ready; instr, instr_fmt, instr_pc stable while stalled.
REQ-026 On transfer: pc=pc+4 modulo 2^64; slot 0 -> slot 1, stay ISSUE; slot 1 -> REQ.
REQ-027 instr==32'h0 in ISSUE: instr_valid=0, go HALT next cycle, pc unchanged.
REQ-028 HALT: halt=1, all request/valid outputs 0; start -> same as IDLE start.
REQ-029 start in REQ, WAIT, ISSUE SHALL be ignored.
REQ-030 Latency: start to first instr_valid = 3 cycles plus bus ack and response wait.

Reset
REQ-031 reset low at clk edge -> IDLE, pc=0, slot=0, buffer=0, every output 0, in any state including mid-fetch.
REQ-032 Response arriving after reset SHALL be ignored.

Configuration
REQ-033 DECODE_TRACE_EN defined: each instr transfer SHALL $display pc, instr hex, fmt; undefined: no display code, identical cycle behaviour.

Structure
REQ-034 Package decode_pkg SHALL hold the fmt enum, opcode localparams, and FSM state enum.
REQ-035 Combinational sub-module instr_classify (opcode -> instr_fmt) SHALL be instantiated once.

Verification
REQ-036 entry=0x1000, resp_data=0x00500093_00A00513 -> fetch_addr 0x1000; issues 0x00A00513 fmt 1 pc 0x1000, then 0x00500093 fmt 1 pc 0x1004, then fetch 0x1008.
REQ-037 entry=0x1004 -> fetch_addr 0x1000, only high half issued with pc 0x1004.
REQ-038 instr_ready low 5 cycles -> instr, fmt, pc unchanged, pc advances once on accept.
REQ-039 low word 0x0000006F, high word 0x00000000 -> fmt 5 issued, then halt=1; start with entry=0x2000 restarts.
REQ-040 reset low during WAIT, resp_valid next cycle -> resp_ack 0, outputs 0, state IDLE.
REQ-041 opcode 1111111 -> fmt 7 issued and accepted normally.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the decode sequencer: instruction format codes, opcode
// constants and FSM states.
package decode_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_SB  = 3'd3,
        FMT_U   = 3'd4,
        FMT_UJ  = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/instr_classify.sv
// Combinational opcode -> instruction format lookup; unknown opcodes map to
// FMT_ILL so they can still be issued.
module instr_classify
    import decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    output fmt_e       o_fmt
);

    always_comb begin
        case (i_opcode)
            OP_OP, OP_OP32:                     o_fmt = FMT_R;
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: o_fmt = FMT_I;
            OP_STORE:                           o_fmt = FMT_S;
            OP_BRANCH:                          o_fmt = FMT_SB;
            OP_LUI, OP_AUIPC:                   o_fmt = FMT_U;
            OP_JAL:                             o_fmt = FMT_UJ;
            default:                            o_fmt = FMT_ILL;
        endcase
    end

endmodule

// File: rtl/decode_sequencer.sv
// Fetches 64-bit words, issues the two 32-bit halves in order and halts on an
// all-zero instruction. Define DECODE_TRACE_EN to print each issued instruction.
module decode_sequencer
    import decode_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [BUS_DATA_WIDTH-1:0] i_entry,
    output logic                      o_fetch_req,
    output logic [BUS_DATA_WIDTH-1:0] o_fetch_addr,
    input  logic                      i_fetch_ack,
    input  logic                      i_resp_valid,
    input  logic [BUS_DATA_WIDTH-1:0] i_resp_data,
    output logic                      o_resp_ack,
    output logic                      o_instr_valid,
    output logic [31:0]               o_instr,
    output logic [2:0]                o_instr_fmt,
    output logic [BUS_DATA_WIDTH-1:0] o_instr_pc,
    input  logic                      i_instr_ready,
    output logic                      o_halt
);

    localparam int W = BUS_DATA_WIDTH;

    state_e       r_state;
    state_e       w_next;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_buf;
    logic         r_slot;

    logic [31:0]  w_instr;
    logic         w_zero;
    logic         w_xfer;
    fmt_e         w_fmt;

    // Tag width only exists for bus compatibility.
    logic [BUS_TAG_WIDTH-1:0] w_unused_tag;
    assign w_unused_tag = '0;

    assign w_instr = r_slot ? r_buf[63:32] : r_buf[31:0];
    assign w_zero  = (w_instr == 32'h0);
    assign w_xfer  = (r_state == ST_ISSUE) && !w_zero && i_instr_ready;

    instr_classify u_classify (
        .i_opcode (w_instr[6:0]),
        .o_fmt    (w_fmt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: if (i_start) w_next = ST_REQ;
            ST_REQ:           if (i_fetch_ack) w_next = ST_WAIT;
            ST_WAIT:          if (i_resp_valid) w_next = ST_ISSUE;
            ST_ISSUE: begin
                if (w_zero)              w_next = ST_HALT;
                else if (i_instr_ready && r_slot) w_next = ST_REQ;
            end
            default:          w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc   <= '0;
            r_buf  <= '0;
            r_slot <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: if (i_start) r_pc <= i_entry & ~W'(3);
                ST_WAIT: begin
                    if (i_resp_valid) begin
                        r_buf  <= i_resp_data;
                        r_slot <= r_pc[2];
                    end
                end
                // Slot 1 after a transfer is only meaningful in slot-0 case;
                // a slot-1 transfer leaves for REQ and WAIT reloads it.
                ST_ISSUE: begin
                    if (w_xfer) begin
                        r_pc   <= r_pc + W'(4);
                        r_slot <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_fetch_req   = 1'b0;
        o_fetch_addr  = '0;
        o_resp_ack    = 1'b0;
        o_instr_valid = 1'b0;
        o_instr       = '0;
        o_instr_fmt   = '0;
        o_instr_pc    = '0;
        o_halt        = 1'b0;
        case (r_state)
            ST_REQ: begin
                o_fetch_req  = 1'b1;
                o_fetch_addr = {r_pc[W-1:3], 3'b000};
            end
            ST_WAIT:  o_resp_ack = i_resp_valid;
            ST_ISSUE: begin
                o_instr_valid = !w_zero;
                o_instr       = w_instr;
                o_instr_fmt   = w_fmt;
                o_instr_pc    = r_pc;
            end
            ST_HALT:  o_halt = 1'b1;
            default: ;
        endcase
    end

`ifdef DECODE_TRACE_EN
    always_ff @(posedge i_clk) begin
        if (i_reset && w_xfer)
            $display("decode pc=%h instr=%h fmt=%0d", r_pc, w_instr, w_fmt);
    end
`endif

endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: a memory/bus model answers fetches,
// expected issues are queued per program and popped on each transfer.
module tb_decode_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] entry = '0;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic        fetch_ack = 1'b0;
    logic        resp_valid = 1'b0;
    logic [63:0] resp_data = '0;
    logic        resp_ack;
    logic        instr_valid;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] ipc;
    logic        ready = 1'b0;
    logic        halt;

    always #5 clk = ~clk;

    decode_sequencer #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_entry(entry),
        .o_fetch_req(fetch_req), .o_fetch_addr(fetch_addr), .i_fetch_ack(fetch_ack),
        .i_resp_valid(resp_valid), .i_resp_data(resp_data), .o_resp_ack(resp_ack),
        .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_fmt(fmt),
        .o_instr_pc(ipc), .i_instr_ready(ready), .o_halt(halt)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] fq[$];
    logic [63:0] mem [logic [63:0]];

    bit bus_en = 1'b0;
    int resp_dly = 0;
    int stall_pct = 0;
    int stall_n = 0;

    function automatic logic [2:0] ref_fmt(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0111011:                         return 3'd0;
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: return 3'd1;
            7'b0100011:                                     return 3'd2;
            7'b1100011:                                     return 3'd3;
            7'b0110111, 7'b0010111:                         return 3'd4;
            7'b1101111:                                     return 3'd5;
            default:                                        return 3'd7;
        endcase
    endfunction

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    task automatic put(input logic [63:0] pc, input logic [31:0] ins);
        logic [63:0] a;
        logic [63:0] w;
        a = {pc[63:3], 3'b000};
        w = mem_rd(a);
        if (pc[2]) w[63:32] = ins;
        else       w[31:0]  = ins;
        mem[a] = w;
    endtask

    task automatic exp_push(input logic [31:0] ins, input logic [2:0] f, input logic [63:0] pc);
        exp_t e;
        e.instr = ins;
        e.fmt   = f;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    // Bus/memory model: ack a request, answer after resp_dly cycles, drop
    // resp_valid once the DUT has consumed it.
    bit          pend = 1'b0;
    bit          got_ack = 1'b0;
    logic [63:0] paddr;
    int          dly;
    always @(negedge clk) begin
        if (!bus_en) begin
            pend    = 1'b0;
            got_ack = 1'b0;
        end else begin
            fetch_ack = 1'b0;
            if (resp_valid && got_ack) begin
                resp_valid = 1'b0;
                got_ack    = 1'b0;
            end
            if (pend) begin
                if (dly == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_rd(paddr);
                    pend       = 1'b0;
                end else dly--;
            end else if (fetch_req && !resp_valid) begin
                fetch_ack = 1'b1;
                paddr     = fetch_addr;
                if (fq.size() != 0) chk("faddr", fetch_addr, fq.pop_front());
                else                chk("fetch_unexpected", fq.size(), 1);
                pend = 1'b1;
                dly  = resp_dly;
            end
            #1;
            if (resp_valid) got_ack = resp_ack;
        end
    end

    // Decoder side: ready driver plus scoreboard compare on every offered cycle.
    always @(negedge clk) begin
        if (instr_valid && stall_n > 0) begin
            ready = 1'b0;
            stall_n--;
        end else begin
            ready = ($urandom_range(99) >= stall_pct);
        end
        #3;
        if (instr_valid) begin
            if (exp_q.size() == 0) chk("issue_unexpected", exp_q.size(), 1);
            else begin
                chk("instr", instr, exp_q[0].instr);
                chk("fmt", fmt, exp_q[0].fmt);
                chk("pc", ipc, exp_q[0].pc);
                if (ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic go(input logic [63:0] e);
        @(negedge clk);
        start = 1'b1;
        entry = e;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        while (!halt && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halt"}, halt, 1);
        chk({tag, "_hvalid"}, instr_valid, 0);
        chk({tag, "_hreq"}, fetch_req, 0);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_fq"}, fq.size(), 0);
    endtask

    initial begin
        logic [6:0]  ops [12];
        logic [63:0] e;
        logic [31:0] r;
        logic [31:0] ins;
        int          n;

        ops = '{7'b0110011, 7'b0111011, 7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_req", fetch_req, 0);
        chk("rst_faddr", fetch_addr, 0);
        chk("rst_rack", resp_ack, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_fmt", fmt, 0);
        chk("rst_pc", ipc, 0);
        chk("rst_halt", halt, 0);
        bus_en = 1'b1;

        // Two I-type instructions, then a zero word; also measures start latency.
        mem[64'h1000] = 64'h00500093_00A00513;
        fq.push_back(64'h1000);
        fq.push_back(64'h1008);
        exp_push(32'h00A00513, 3'd1, 64'h1000);
        exp_push(32'h00500093, 3'd1, 64'h1004);
        @(negedge clk);
        start = 1'b1;
        entry = 64'h1000;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 3);
        wait_halt("t1");

        // Odd-word entry: only the high half is issued.
        fq.push_back(64'h1000);
        fq.push_back(64'h1008);
        exp_push(32'h00500093, 3'd1, 64'h1004);
        go(64'h1004);
        wait_halt("t2");

        // Long stall on the first instruction; R, S, SB formats.
        mem.delete();
        mem[64'h3000] = 64'h00112023_002081B3;
        mem[64'h3008] = 64'h00000000_00000463;
        fq.push_back(64'h3000);
        fq.push_back(64'h3008);
        exp_push(32'h002081B3, 3'd0, 64'h3000);
        exp_push(32'h00112023, 3'd2, 64'h3004);
        exp_push(32'h00000463, 3'd3, 64'h3008);
        stall_n = 5;
        resp_dly = 2;
        go(64'h3000);
        wait_halt("t3");

        // JAL then zero high word -> halt; restart from HALT with illegal opcode,
        // and a start pulse mid-ISSUE that must be ignored.
        mem[64'h4000] = 64'h00000000_0000006F;
        fq.push_back(64'h4000);
        exp_push(32'h0000006F, 3'd5, 64'h4000);
        resp_dly = 0;
        go(64'h4000);
        wait_halt("t4");
        mem[64'h2000] = 64'h00001037_0000007F;
        fq.push_back(64'h2000);
        fq.push_back(64'h2008);
        exp_push(32'h0000007F, 3'd7, 64'h2000);
        exp_push(32'h00001037, 3'd4, 64'h2004);
        stall_n = 4;
        go(64'h2000);
        n = 0;
        while (!instr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_issue_seen", instr_valid, 1);
        start = 1'b1;
        entry = 64'h9000;
        @(negedge clk);
        start = 1'b0;
        wait_halt("t4b");

        // Reset while waiting for the response; the late response is ignored.
        bus_en = 1'b0;
        mem[64'h5000] = 64'h00000013_00000013;
        go(64'h5000);
        chk("t5_req", fetch_req, 1);
        fetch_ack = 1'b1;
        @(negedge clk);
        fetch_ack = 1'b0;
        chk("t5_rack_wait", resp_ack, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        resp_valid = 1'b1;
        resp_data = 64'h00000013_00000013;
        #1;
        chk("t5_rack", resp_ack, 0);
        chk("t5_req0", fetch_req, 0);
        chk("t5_valid", instr_valid, 0);
        chk("t5_halt", halt, 0);
        @(negedge clk);
        chk("t5_valid2", instr_valid, 0);
        chk("t5_req2", fetch_req, 0);
        chk("t5_rack2", resp_ack, 0);
        chk("t5_halt2", halt, 0);
        resp_valid = 1'b0;
        bus_en = 1'b1;

        // Random programs: random opcodes, entry low bits, stalls and delays.
        stall_pct = 30;
        for (int k = 0; k < 6; k++) begin
            mem.delete();
            e = 64'h10000 * (k + 1) + 64'($urandom_range(63)) * 4;
            n = $urandom_range(9, 1);
            for (int i = 0; i < n; i++) begin
                r = $urandom();
                ins = {r[31:8], 1'b1, ops[$urandom_range(11)]};
                put(e + 64'(4 * i), ins);
                exp_push(ins, ref_fmt(ins[6:0]), e + 64'(4 * i));
            end
            put(e + 64'(4 * n), 32'h0);
            for (logic [63:0] a = {e[63:3], 3'b000}; a <= e + 64'(4 * n); a += 8)
                fq.push_back(a);
            resp_dly = $urandom_range(3);
            go(e | 64'($urandom_range(3)));
            wait_halt("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
